// File: rtl/regfile_scoreboard.sv
// Register file with write-first bypass and a per-register pending-write scoreboard.
// Issue stalls combinationally on RAW/WAW hazards; writebacks clear, accepted issues set.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    input  logic                rd_en1,
    input  logic                rd_en2,
    output logic [DATA_W-1:0]   rd_data1,
    output logic [DATA_W-1:0]   rd_data2,
    input  logic                issue_valid,
    input  logic                issue_wb,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                flush,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [ADDR_W:0]     pending_cnt
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [ADDR_W:0]     pending_cnt_q;
    logic [ADDR_W:0]     pending_cnt_d;

    logic [NUM_REGS-1:0] clr;
    logic [NUM_REGS-1:0] set;
    logic                hazard1;
    logic                hazard2;
    logic                waw;
    logic                accept;

    function automatic logic [ADDR_W:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            c = c + {{ADDR_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            clr[i] = wb_valid && (wb_addr == ADDR_W'(i));
        end
    end

    // A writeback landing this cycle resolves the hazard it would otherwise cause.
    always_comb begin
        hazard1 = rd_en1 & busy_q[rd_addr1] & ~clr[rd_addr1];
        hazard2 = rd_en2 & busy_q[rd_addr2] & ~clr[rd_addr2];
        waw     = issue_wb & busy_q[issue_rd] & ~clr[issue_rd];
        stall   = issue_valid & ~flush & (hazard1 | hazard2 | waw);
        accept  = issue_valid & ~stall & ~flush & issue_wb;
    end

    always_comb begin
        rd_data1 = (wb_valid && (wb_addr == rd_addr1)) ? wb_data : regs_q[rd_addr1];
        rd_data2 = (wb_valid && (wb_addr == rd_addr2)) ? wb_data : regs_q[rd_addr2];
    end

    // Set is applied after clear so a same-register issue wins over the writeback.
    always_comb begin
        set = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            set[i] = accept && (issue_rd == ADDR_W'(i));
        end
        if (flush) begin
            busy_d = '0;
        end else begin
            busy_d = (busy_q & ~clr) | set;
        end
        pending_cnt_d = popcount(busy_d);
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = clr[i] ? wb_data : regs_q[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q        <= '0;
            pending_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q        <= busy_d;
            pending_cnt_q <= pending_cnt_d;
        end
    end

    assign busy_vec    = busy_q;
    assign pending_cnt = pending_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_scoreboard;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;

    localparam int SEL_RD1   = 0;
    localparam int SEL_RD2   = 1;
    localparam int SEL_STALL = 2;
    localparam int SEL_BUSY  = 3;
    localparam int SEL_CNT   = 4;

    logic                clock = 1'b0;
    logic                reset;
    logic [ADDR_W-1:0]   rd_addr1, rd_addr2;
    logic                rd_en1, rd_en2;
    logic [DATA_W-1:0]   rd_data1, rd_data2;
    logic                issue_valid, issue_wb;
    logic [ADDR_W-1:0]   issue_rd;
    logic                wb_valid;
    logic [ADDR_W-1:0]   wb_addr;
    logic [DATA_W-1:0]   wb_data;
    logic                flush;
    logic                stall;
    logic [NUM_REGS-1:0] busy_vec;
    logic [ADDR_W:0]     pending_cnt;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    regfile_scoreboard #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)
    ) dut (
        .clock(clock), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_en1(rd_en1), .rd_en2(rd_en2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .issue_valid(issue_valid), .issue_wb(issue_wb), .issue_rd(issue_rd),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .stall(stall),
        .busy_vec(busy_vec), .pending_cnt(pending_cnt)
    );

    always #5 clock = ~clock;

    // Monitor: everything queued for this cycle is compared mid-cycle.
    always @(negedge clock) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = exp_q.pop_front();
            case (e.sel)
                SEL_RD1:   act = rd_data1;
                SEL_RD2:   act = rd_data2;
                SEL_STALL: act = {31'd0, stall};
                SEL_BUSY:  act = {16'd0, busy_vec};
                default:   act = {27'd0, pending_cnt};
            endcase
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val);
            end
        end
    end

    task automatic push_exp(input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; rd_addr1 = '0; rd_addr2 = '0; rd_en1 = 1'b0; rd_en2 = 1'b0;
        issue_valid = 1'b0; issue_wb = 1'b0; issue_rd = '0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] r);
        idle();
        issue_valid = 1'b1; issue_wb = 1'b1; issue_rd = r;
    endtask

    task automatic wb(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wb_valid = 1'b1; wb_addr = a; wb_data = d;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        // Reset state
        idle();
        push_exp("reset_busy", SEL_BUSY, 32'h0);
        push_exp("reset_cnt", SEL_CNT, 32'h0);
        push_exp("reset_rd1", SEL_RD1, 32'h0);
        push_exp("reset_stall", SEL_STALL, 32'h0);
        tick();

        // Write with same-cycle bypass, then plain read
        idle(); wb(4'd3, 32'hDEADBEEF); rd_addr1 = 4'd3; rd_addr2 = 4'd4;
        push_exp("bypass_rd1", SEL_RD1, 32'hDEADBEEF);
        push_exp("no_bypass_rd2", SEL_RD2, 32'h0);
        tick();
        idle(); rd_addr1 = 4'd3;
        push_exp("after_write_rd1", SEL_RD1, 32'hDEADBEEF);
        tick();

        // RAW stall and release
        issue(4'd5);
        push_exp("issue_r5_stall", SEL_STALL, 32'h0);
        tick();
        idle(); issue_valid = 1'b1; rd_en1 = 1'b1; rd_addr1 = 4'd5;
        push_exp("r5_busy", SEL_BUSY, 32'h0020);
        push_exp("r5_cnt", SEL_CNT, 32'h1);
        push_exp("raw_port1_stall", SEL_STALL, 32'h1);
        tick();
        idle(); issue_valid = 1'b1; rd_en1 = 1'b0; rd_addr1 = 4'd5;
        push_exp("raw_rd_en_off", SEL_STALL, 32'h0);
        tick();
        idle(); rd_en1 = 1'b1; rd_addr1 = 4'd5;
        push_exp("raw_no_issue_valid", SEL_STALL, 32'h0);
        tick();
        idle(); issue_valid = 1'b1; rd_en2 = 1'b1; rd_addr2 = 4'd5;
        push_exp("raw_port2_stall", SEL_STALL, 32'h1);
        tick();
        idle(); issue_valid = 1'b1; rd_en1 = 1'b1; rd_addr1 = 4'd5; wb(4'd5, 32'h1234);
        push_exp("raw_release_stall", SEL_STALL, 32'h0);
        push_exp("raw_release_rd1", SEL_RD1, 32'h1234);
        tick();
        idle(); rd_addr1 = 4'd5;
        push_exp("r5_cleared_busy", SEL_BUSY, 32'h0);
        push_exp("r5_cleared_cnt", SEL_CNT, 32'h0);
        push_exp("r5_data", SEL_RD1, 32'h1234);
        tick();

        // Simultaneous set and clear on r7
        issue(4'd7);
        tick();
        issue(4'd7); wb(4'd7, 32'h77);
        push_exp("r7_busy_before", SEL_BUSY, 32'h0080);
        push_exp("r7_setclr_stall", SEL_STALL, 32'h0);
        tick();
        idle(); wb(4'd7, 32'h78);
        push_exp("r7_set_wins_busy", SEL_BUSY, 32'h0080);
        push_exp("r7_set_wins_cnt", SEL_CNT, 32'h1);
        tick();
        idle();
        push_exp("r7_cleared", SEL_BUSY, 32'h0);
        tick();

        // WAW on r2
        issue(4'd2);
        tick();
        issue(4'd2);
        push_exp("waw_stall", SEL_STALL, 32'h1);
        tick();
        idle(); wb(4'd2, 32'h22);
        push_exp("waw_busy_unchanged", SEL_BUSY, 32'h0004);
        push_exp("waw_cnt_unchanged", SEL_CNT, 32'h1);
        tick();
        // Writeback to a non-busy register leaves busy alone
        idle(); wb(4'd8, 32'h88);
        push_exp("r2_cleared", SEL_BUSY, 32'h0);
        tick();
        idle(); rd_addr1 = 4'd8;
        push_exp("nonbusy_wb_busy", SEL_BUSY, 32'h0);
        push_exp("nonbusy_wb_cnt", SEL_CNT, 32'h0);
        push_exp("nonbusy_wb_data", SEL_RD1, 32'h88);
        tick();

        // Flush with concurrent writeback and issue
        issue(4'd1); tick();
        issue(4'd4); tick();
        issue(4'd9); tick();
        idle(); flush = 1'b1; wb(4'd4, 32'h55);
        issue_valid = 1'b1; issue_wb = 1'b1; issue_rd = 4'd10;
        rd_en1 = 1'b1; rd_addr1 = 4'd1;
        push_exp("preflush_busy", SEL_BUSY, 32'h0212);
        push_exp("preflush_cnt", SEL_CNT, 32'h3);
        push_exp("flush_masks_stall", SEL_STALL, 32'h0);
        tick();
        idle(); rd_addr1 = 4'd4;
        push_exp("flush_busy", SEL_BUSY, 32'h0);
        push_exp("flush_cnt", SEL_CNT, 32'h0);
        push_exp("flush_wb_data", SEL_RD1, 32'h55);
        tick();

        // Reset mid-operation
        idle(); wb(4'd0, 32'hFF); tick();
        issue(4'd1); tick();
        issue(4'd2); tick();
        issue(4'd3); tick();
        issue(4'd4); tick();
        idle(); rd_addr1 = 4'd0;
        push_exp("prereset_busy", SEL_BUSY, 32'h001E);
        push_exp("prereset_cnt", SEL_CNT, 32'h4);
        push_exp("prereset_r0", SEL_RD1, 32'hFF);
        tick();
        idle(); reset = 1'b1; wb(4'd0, 32'hAB);
        issue_valid = 1'b1; issue_wb = 1'b1; issue_rd = 4'd6;
        rd_en1 = 1'b1; rd_addr1 = 4'd1;
        push_exp("stall_during_reset", SEL_STALL, 32'h1);
        tick();
        idle(); rd_addr1 = 4'd0; rd_addr2 = 4'd3;
        push_exp("postreset_busy", SEL_BUSY, 32'h0);
        push_exp("postreset_cnt", SEL_CNT, 32'h0);
        push_exp("postreset_r0", SEL_RD1, 32'h0);
        push_exp("postreset_r3", SEL_RD2, 32'h0);
        tick();

        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: got %0d left expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter DATA_W, default 32: register data width in bits.
REQ-002 Parameter NUM_REGS, default 16: number of architectural registers (power of two, 2..64).
REQ-003 Parameter ADDR_W, default $clog2(NUM_REGS): register address width.
REQ-004 One clock; reset is synchronous and active-high. Ports: clock, in, 1, rising-edge clock; reset, in, 1, synchronous active-high reset.
REQ-005 rd_addr1 / rd_addr2, in, ADDR_W each: read port addresses (operand fetch).
REQ-006 rd_en1 / rd_en2, in, 1 each: the read port is a true source operand and is hazard-checked.
REQ-007 rd_data1 / rd_data2, out, DATA_W each: read data.
REQ-008 issue_valid, in, 1: decoded instruction presented for issue.
REQ-009 issue_wb, in, 1: the issuing instruction writes a register (isWb).
REQ-010 issue_rd, in, ADDR_W: destination register of the issuing instruction.
REQ-011 wb_valid, in, 1: writeback enable; wb_addr, in, ADDR_W; wb_data, in, DATA_W.
REQ-012 flush, in, 1: pipeline flush; cancels all outstanding writes.
REQ-013 stall, out, 1: the issue is blocked this cycle.
REQ-014 busy_vec, out, NUM_REGS: per-register pending-write bits.
REQ-015 pending_cnt, out, ADDR_W+1: number of set busy bits.

Function
REQ-016 Reads SHALL be combinational: rd_dataN = reg[rd_addrN].
REQ-017 Write-first bypass: if wb_valid and wb_addr == rd_addrN in the same cycle, rd_dataN SHALL equal wb_data.
REQ-018 On a rising clock edge with wb_valid=1, reg[wb_addr] SHALL take wb_data. No register is hardwired to zero.
REQ-019 clr[i] = wb_valid & (wb_addr == i). Hazard on port N = rd_enN & busy[rd_addrN] & ~clr[rd_addrN].
REQ-020 WAW hazard = issue_wb & busy[issue_rd] & ~clr[issue_rd].
REQ-021 stall SHALL equal issue_valid & ~flush & (hazard1 | hazard2 | WAW). It is purely combinational, and its latency is 0 cycles.
REQ-022 Accepted issue: issue_valid & ~stall & ~flush & issue_wb. It SHALL set busy[issue_rd] at the next edge.
REQ-023 A writeback SHALL clear busy[wb_addr] at the next edge. If an accepted issue targets the same register in the same cycle, set SHALL win.
REQ-024 A writeback to a register that is not busy SHALL update data and leave busy unchanged (no error, no underflow).
REQ-025 flush=1 SHALL clear all busy bits at the next edge. Any issue that cycle SHALL be discarded. The writeback that cycle SHALL still update data.
REQ-026 pending_cnt SHALL be the registered population count of busy_vec, updated on the same edge as busy_vec. Range 0..NUM_REGS, with no wrap.
REQ-027 busy_vec and pending_cnt SHALL be register outputs. rd_data and stall are combinational outputs.
REQ-028 Out-of-range addresses cannot occur, because NUM_REGS = 2^ADDR_W is required.

Reset
REQ-029 With reset=1 at a rising edge, all registers SHALL be 0, busy_vec SHALL be 0 and pending_cnt SHALL be 0 after that edge.
REQ-030 Reset SHALL take priority over wb_valid, issue and flush in the same cycle.
REQ-031 Reset asserted mid-operation SHALL discard all pending writes.
REQ-032 While reset=1, stall SHALL still be computed from the current busy_vec.

Verification
REQ-033 Write/read with bypass:
- Step 1: wb_valid=1, wb_addr=3, wb_data=0xDEADBEEF, rd_addr1=3, same cycle -> rd_data1=0xDEADBEEF combinationally.
- Step 2: next cycle, wb_valid=0 -> rd_data1 still 0xDEADBEEF.
REQ-034 RAW stall and release:
- Step 1: issue_wb to r5 is accepted -> busy_vec[5]=1, pending_cnt=1.
- Step 2: issue with rd_en1=1, rd_addr1=5, no writeback -> stall=1.
- Step 3: same cycle as wb_valid to r5 with data 0x1234 -> stall=0 and rd_data1=0x1234.
REQ-035 Simultaneous set and clear:
- Stimulus: busy[7]=1, then wb to r7 in the same cycle as an accepted issue_rd=7.
- Required response: busy[7]=1 next cycle, pending_cnt unchanged.
REQ-036 WAW:
- Stimulus: busy[2]=1, then issue_wb with issue_rd=2.
- Required response: stall=1, busy_vec unchanged.
REQ-037 Flush:
- Stimulus: r1, r4 and r9 busy (pending_cnt=3), then flush=1 together with wb to r4 (data 0x55) and a valid issue.
- Required response: next cycle busy_vec=0, pending_cnt=0 and reg[4]=0x55.
REQ-038 Reset mid-operation:
- Stimulus: 4 registers busy and r0=0xFF, then reset=1 for one edge, also with wb_valid=1 in that cycle.
- Required response: all registers 0, busy_vec=0, pending_cnt=0.
